score_bcd_scheduler: RTL

SCORE_BCD_SCHEDULER -- requirements
Module: score_bcd_scheduler

---
 rtl/score_bcd_scheduler_pkg.sv | 22 ++
 rtl/bin2bcd_iter.sv | 42 ++++
 rtl/score_bcd_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/score_bcd_scheduler_pkg.sv
// Shared constants for the score display: scheduler states, read-source codes
// and the per-frame conversion timeline.
package score_bcd_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        COMMIT
    } state_e;

    localparam logic [1:0] SRC_POINTS = 2'd0;
    localparam logic [1:0] SRC_LINES  = 2'd1;
    localparam logic [1:0] SRC_LEVEL  = 2'd2;
    localparam logic [1:0] SRC_NONE   = 2'd3;

    // One source = LOAD + SRC_W shifts + STORE; three sources, then COMMIT.
    localparam int CYCLES_PER_SRC = 28;
    localparam int COMMIT_CYCLE   = 85;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble engine: load a binary value, then one
// adjust-and-shift step per shift pulse; bcd is valid after SRC_W shifts.
module bin2bcd_iter #(
    parameter int SRC_W      = 26,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    shift,
    input  logic [SRC_W-1:0]        din,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int BW = 4 * NUM_DIGITS;

    logic [SRC_W-1:0] bin_q;
    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else if (load) begin
            bin_q <= din;
            bcd_q <= '0;
        end else if (shift) begin
            bcd_q <= {adj[BW-2:0], bin_q[SRC_W-1]};
            bin_q <= {bin_q[SRC_W-2:0], 1'b0};
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/score_bcd_scheduler.sv
// Per-frame BCD conversion of points, lines and level with an atomic commit
// to display registers and a registered digit read port.
module score_bcd_scheduler
    import score_bcd_scheduler_pkg::*;
#(
    parameter int SRC_W      = 26,
    parameter int NUM_DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [SRC_W-1:0] game_points,
    input  logic [SRC_W-1:0] game_lines,
    input  logic [3:0]       game_level,
    input  logic [1:0]       rd_sel,
    input  logic [2:0]       rd_digit,
    output logic [3:0]       rd_bcd,
    output logic             rd_lz,
    output logic             busy,
    output logic             done,
    output logic             overrun
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(SRC_W + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(SRC_W - 1);

    state_e           state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SRC_W-1:0] snap_pts_q, snap_lin_q;
    logic [3:0]       snap_lvl_q;
    logic [BW-1:0]    stg_pts_q, stg_lin_q, stg_lvl_q;
    logic [BW-1:0]    disp_pts_q, disp_lin_q, disp_lvl_q;
    logic [BW-1:0]    disp_pts_d, disp_lin_d, disp_lvl_d;
    logic             done_q, overrun_q;
    logic [3:0]       rd_bcd_q, rd_bcd_d;
    logic             rd_lz_q, rd_lz_d;

    logic             eng_load, eng_shift;
    logic [SRC_W-1:0] eng_din;
    logic [BW-1:0]    eng_bcd;
    logic [BW-1:0]    rd_val;

    bin2bcd_iter #(
        .SRC_W     (SRC_W),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (eng_load),
        .shift(eng_shift),
        .din  (eng_din),
        .bcd  (eng_bcd)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        eng_load  = 1'b0;
        eng_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = LOAD;
                    src_d   = SRC_POINTS;
                end
            end
            LOAD: begin
                eng_load = 1'b1;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                eng_shift = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) state_d = STORE;
            end
            STORE: begin
                if (src_q == SRC_LEVEL) begin
                    state_d = COMMIT;
                end else begin
                    src_d   = src_q + 2'd1;
                    state_d = LOAD;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (src_q)
            SRC_POINTS: eng_din = snap_pts_q;
            SRC_LINES:  eng_din = snap_lin_q;
            default:    eng_din = {{(SRC_W-4){1'b0}}, snap_lvl_q};
        endcase
    end

    // Read port samples the next display value so new digits show up
    // in the same cycle as done.
    always_comb begin
        disp_pts_d = disp_pts_q;
        disp_lin_d = disp_lin_q;
        disp_lvl_d = disp_lvl_q;
        if (state_q == COMMIT) begin
            disp_pts_d = stg_pts_q;
            disp_lin_d = stg_lin_q;
            disp_lvl_d = stg_lvl_q;
        end
        case (rd_sel)
            SRC_POINTS: rd_val = disp_pts_d;
            SRC_LINES:  rd_val = disp_lin_d;
            SRC_LEVEL:  rd_val = disp_lvl_d;
            default:    rd_val = '0;
        endcase
        rd_bcd_d = 4'd0;
        rd_lz_d  = 1'b1;
        if (rd_sel != SRC_NONE && !(rd_sel == SRC_LEVEL && rd_digit >= 3'd2)
            && int'(rd_digit) < NUM_DIGITS) begin
            rd_bcd_d = rd_val[4*rd_digit +: 4];
            rd_lz_d  = (rd_digit != 3'd0) && ((rd_val >> (4*rd_digit)) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_POINTS;
            cnt_q      <= '0;
            snap_pts_q <= '0;
            snap_lin_q <= '0;
            snap_lvl_q <= '0;
            stg_pts_q  <= '0;
            stg_lin_q  <= '0;
            stg_lvl_q  <= '0;
            disp_pts_q <= '0;
            disp_lin_q <= '0;
            disp_lvl_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rd_bcd_q   <= 4'd0;
            rd_lz_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            disp_pts_q <= disp_pts_d;
            disp_lin_q <= disp_lin_d;
            disp_lvl_q <= disp_lvl_d;
            done_q     <= (state_q == COMMIT);
            rd_bcd_q   <= rd_bcd_d;
            rd_lz_q    <= rd_lz_d;
            if (frame_start) begin
                if (state_q == IDLE) begin
                    snap_pts_q <= game_points;
                    snap_lin_q <= game_lines;
                    snap_lvl_q <= game_level;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            if (state_q == STORE) begin
                case (src_q)
                    SRC_POINTS: stg_pts_q <= eng_bcd;
                    SRC_LINES:  stg_lin_q <= eng_bcd;
                    default:    stg_lvl_q <= eng_bcd;
                endcase
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign overrun = overrun_q;
    assign rd_bcd  = rd_bcd_q;
    assign rd_lz   = rd_lz_q;

endmodule
